// File: rtl/eth_rst_seq.sv
// Ethernet reset/timebase sequencer.
// Qualifies locks, then releases stage resets in order.
module eth_rst_seq #(
  parameter int unsigned CLK_PER_US = 125,
  parameter int unsigned US_PER_MS  = 1000,
  parameter int unsigned NSTAGE     = 4,
  parameter int unsigned LOCK_N     = 3,
  parameter logic [NSTAGE*16-1:0] STAGE_MS =
    {16'd1, 16'd1, 16'd32, 16'd1},
  parameter int unsigned LOCK_MS    = 10,
  parameter int unsigned HOLD_MS    = 2
) (
  input  logic              clki,
  input  logic              arst_ni,
  input  logic [LOCK_N-1:0] lock_i,
  input  logic              soft_rst_i,
  output logic [NSTAGE-1:0] stage_rstn_o,
  output logic              done_o,
  output logic              tick_us_o,
  output logic              tick_ms_o,
  output logic [1:0]        state_o,
  output logic [7:0]        reseq_cnt_o
);

  localparam int UW = $clog2(CLK_PER_US);
  localparam int MW = $clog2(US_PER_MS);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_REL  = 2'd1,
    S_RUN  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  logic [UW-1:0]     us_cnt;
  logic [MW-1:0]     ms_cnt;
  logic              us_wrap;
  logic              ms_wrap;
  logic [LOCK_N-1:0] lock_s1;
  logic [LOCK_N-1:0] lock_s2;
  logic              lock_ok;
  logic              fault;

  state_t            state, state_n;
  logic [2:0]        k, k_n;
  logic [15:0]       dly, dly_n;
  logic [15:0]       stage_dly;
  logic [NSTAGE-1:0] rstn_n;
  logic              done_n;
  logic [7:0]        reseq_n;

  assign us_wrap = us_cnt == UW'(CLK_PER_US - 1);
  assign ms_wrap = ms_cnt == MW'(US_PER_MS - 1);
  assign lock_ok = &lock_s2;
  assign fault   = !lock_ok || soft_rst_i;
  assign state_o = state;

  always_ff @(posedge clki or negedge arst_ni) begin
    if (!arst_ni) begin
      us_cnt    <= '0;
      ms_cnt    <= '0;
      tick_us_o <= 1'b0;
      tick_ms_o <= 1'b0;
      lock_s1   <= '0;
      lock_s2   <= '0;
    end else begin
      tick_us_o <= us_wrap;
      tick_ms_o <= us_wrap && ms_wrap;
      us_cnt    <= us_wrap ? '0 : us_cnt + UW'(1);
      if (us_wrap)
        ms_cnt <= ms_wrap ? '0 : ms_cnt + MW'(1);
      lock_s1   <= lock_i;
      lock_s2   <= lock_s1;
    end
  end

  always_comb begin
    stage_dly = '0;
    for (int i = 0; i < NSTAGE; i++)
      if (k == 3'(i))
        stage_dly = STAGE_MS[i*16 +: 16];
  end

  always_comb begin
    state_n = state;
    k_n     = k;
    dly_n   = dly;
    rstn_n  = stage_rstn_o;
    done_n  = done_o;
    reseq_n = reseq_cnt_o;
    if (tick_ms_o && dly != 16'hFFFF)
      dly_n = dly + 16'd1;
    unique case (state)
      S_WAIT: begin
        rstn_n = '0;
        done_n = 1'b0;
        if (fault) begin
          dly_n = '0;
        end else if (dly == 16'(LOCK_MS)) begin
          state_n = S_REL;
          k_n     = '0;
          dly_n   = '0;
        end
      end
      S_REL, S_RUN: begin
        // A fault wins over a stage release in the same cycle
        if (fault) begin
          state_n = S_HOLD;
          rstn_n  = '0;
          done_n  = 1'b0;
          dly_n   = '0;
          if (reseq_cnt_o != 8'hFF)
            reseq_n = reseq_cnt_o + 8'd1;
        end else if (state == S_REL && dly == stage_dly) begin
          rstn_n = stage_rstn_o | (NSTAGE'(1) << k);
          dly_n  = '0;
          if (k == 3'(NSTAGE - 1)) begin
            state_n = S_RUN;
            done_n  = 1'b1;
          end else begin
            k_n = k + 3'd1;
          end
        end
      end
      S_HOLD: begin
        rstn_n = '0;
        done_n = 1'b0;
        if (dly == 16'(HOLD_MS)) begin
          state_n = S_WAIT;
          dly_n   = '0;
        end
      end
      default: state_n = S_WAIT;
    endcase
  end

  always_ff @(posedge clki or negedge arst_ni) begin
    if (!arst_ni) begin
      state        <= S_WAIT;
      k            <= '0;
      dly          <= '0;
      stage_rstn_o <= '0;
      done_o       <= 1'b0;
      reseq_cnt_o  <= '0;
    end else begin
      state        <= state_n;
      k            <= k_n;
      dly          <= dly_n;
      stage_rstn_o <= rstn_n;
      done_o       <= done_n;
      reseq_cnt_o  <= reseq_n;
    end
  end

endmodule

// File: tb/tb_eth_rst_seq.sv
// Directed bench for eth_rst_seq.
// 20-cycle ms, three stages, two locks.
module tb_eth_rst_seq;

  logic       clki = 1'b0;
  logic       arst_ni = 1'b0;
  logic [1:0] lock_i = 2'b11;
  logic       soft_rst_i = 1'b0;
  logic [2:0] stage_rstn_o;
  logic       done_o;
  logic       tick_us_o;
  logic       tick_ms_o;
  logic [1:0] state_o;
  logic [7:0] reseq_cnt_o;

  int cyc;
  int total = 0;
  int bad = 0;

  eth_rst_seq #(
    .CLK_PER_US(4),
    .US_PER_MS(5),
    .NSTAGE(3),
    .LOCK_N(2),
    .STAGE_MS({16'd2, 16'd0, 16'd1}),
    .LOCK_MS(3),
    .HOLD_MS(2)
  ) dut (
    .clki(clki),
    .arst_ni(arst_ni),
    .lock_i(lock_i),
    .soft_rst_i(soft_rst_i),
    .stage_rstn_o(stage_rstn_o),
    .done_o(done_o),
    .tick_us_o(tick_us_o),
    .tick_ms_o(tick_ms_o),
    .state_o(state_o),
    .reseq_cnt_o(reseq_cnt_o)
  );

  always #5 clki = ~clki;

  // cyc = rising edges since arst_ni was last released
  always @(posedge clki or negedge arst_ni)
    if (!arst_ni) cyc <= 0;
    else          cyc <= cyc + 1;

  task automatic goto(input int n);
    while (cyc < n) @(negedge clki);
  endtask

  task automatic test_reset;
    @(negedge clki);
    arst_ni = 1'b0;
    #1;
    total++;
    if (stage_rstn_o !== 3'b000 || done_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_rstn rstn=%b done=%b want 000/0",
               stage_rstn_o, done_o);
    end
    total++;
    if (tick_us_o !== 1'b0 || tick_ms_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_tick us=%b ms=%b want 0/0",
               tick_us_o, tick_ms_o);
    end
    total++;
    if (state_o !== 2'd0 || reseq_cnt_o !== 8'd0) begin
      bad++;
      $display("FAIL reset_state st=%0d rs=%0d want 0/0",
               state_o, reseq_cnt_o);
    end
    @(negedge clki);
    arst_ni = 1'b1;
  endtask

  task automatic test_ticks;
    for (int n = 1; n <= 60; n++) begin
      goto(n);
      total++;
      if (tick_us_o !== (n % 4 == 0)) begin
        bad++;
        $display("FAIL tick_us cyc=%0d got=%b want=%b",
                 n, tick_us_o, (n % 4 == 0));
      end
      total++;
      if (tick_ms_o !== (n % 20 == 0)) begin
        bad++;
        $display("FAIL tick_ms cyc=%0d got=%b want=%b",
                 n, tick_ms_o, (n % 20 == 0));
      end
    end
  endtask

  task automatic test_release;
    goto(61);
    total++;
    if (state_o !== 2'd0) begin
      bad++;
      $display("FAIL rel_c61 state=%0d want 0", state_o);
    end
    goto(62);
    total++;
    if (state_o !== 2'd1 || stage_rstn_o !== 3'b000) begin
      bad++;
      $display("FAIL rel_c62 st=%0d rstn=%b want 1/000",
               state_o, stage_rstn_o);
    end
    goto(81);
    total++;
    if (stage_rstn_o !== 3'b000) begin
      bad++;
      $display("FAIL rel_c81 rstn=%b want 000", stage_rstn_o);
    end
    goto(82);
    total++;
    if (stage_rstn_o !== 3'b001) begin
      bad++;
      $display("FAIL rel_c82 rstn=%b want 001", stage_rstn_o);
    end
    goto(83);
    total++;
    if (stage_rstn_o !== 3'b011 || state_o !== 2'd1) begin
      bad++;
      $display("FAIL rel_c83 rstn=%b st=%0d want 011/1",
               stage_rstn_o, state_o);
    end
    goto(121);
    total++;
    if (stage_rstn_o !== 3'b011 || done_o !== 1'b0) begin
      bad++;
      $display("FAIL rel_c121 rstn=%b done=%b want 011/0",
               stage_rstn_o, done_o);
    end
    goto(122);
    total++;
    if (stage_rstn_o !== 3'b111 || done_o !== 1'b1 ||
        state_o !== 2'd2) begin
      bad++;
      $display("FAIL rel_c122 rstn=%b done=%b st=%0d want 111/1/2",
               stage_rstn_o, done_o, state_o);
    end
  endtask

  task automatic test_fault_run;
    goto(130);
    lock_i = 2'b10;
    goto(132);
    total++;
    if (state_o !== 2'd2) begin
      bad++;
      $display("FAIL flt_c132 state=%0d want 2", state_o);
    end
    goto(133);
    total++;
    if (state_o !== 2'd3 || stage_rstn_o !== 3'b000 ||
        done_o !== 1'b0 || reseq_cnt_o !== 8'd1) begin
      bad++;
      $display("FAIL flt_c133 st=%0d rstn=%b done=%b rs=%0d want 3/000/0/1",
               state_o, stage_rstn_o, done_o, reseq_cnt_o);
    end
    goto(161);
    total++;
    if (state_o !== 2'd3) begin
      bad++;
      $display("FAIL flt_c161 state=%0d want 3", state_o);
    end
    goto(162);
    total++;
    if (state_o !== 2'd0) begin
      bad++;
      $display("FAIL flt_c162 state=%0d want 0", state_o);
    end
    goto(170);
    lock_i = 2'b11;
    goto(221);
    total++;
    if (state_o !== 2'd0) begin
      bad++;
      $display("FAIL flt_c221 state=%0d want 0", state_o);
    end
    goto(222);
    total++;
    if (state_o !== 2'd1) begin
      bad++;
      $display("FAIL flt_c222 state=%0d want 1", state_o);
    end
    goto(242);
    total++;
    if (stage_rstn_o !== 3'b001) begin
      bad++;
      $display("FAIL flt_c242 rstn=%b want 001", stage_rstn_o);
    end
    goto(243);
    total++;
    if (stage_rstn_o !== 3'b011 || reseq_cnt_o !== 8'd1) begin
      bad++;
      $display("FAIL flt_c243 rstn=%b rs=%0d want 011/1",
               stage_rstn_o, reseq_cnt_o);
    end
  endtask

  task automatic test_async_reset;
    goto(250);
    total++;
    if (state_o !== 2'd1 || stage_rstn_o !== 3'b011) begin
      bad++;
      $display("FAIL ar_pre st=%0d rstn=%b want 1/011",
               state_o, stage_rstn_o);
    end
    arst_ni = 1'b0;
    #1;
    total++;
    if (stage_rstn_o !== 3'b000 || done_o !== 1'b0 ||
        state_o !== 2'd0 || reseq_cnt_o !== 8'd0) begin
      bad++;
      $display("FAIL ar_clear rstn=%b done=%b st=%0d rs=%0d want 0",
               stage_rstn_o, done_o, state_o, reseq_cnt_o);
    end
    @(negedge clki);
    arst_ni = 1'b1;
    goto(4);
    total++;
    if (tick_us_o !== 1'b1) begin
      bad++;
      $display("FAIL ar_us4 tick_us=%b want 1", tick_us_o);
    end
    goto(19);
    total++;
    if (tick_ms_o !== 1'b0) begin
      bad++;
      $display("FAIL ar_ms19 tick_ms=%b want 0", tick_ms_o);
    end
    goto(20);
    total++;
    if (tick_ms_o !== 1'b1) begin
      bad++;
      $display("FAIL ar_ms20 tick_ms=%b want 1", tick_ms_o);
    end
  endtask

  task automatic test_lock_glitch;
    goto(41);
    total++;
    if (state_o !== 2'd0) begin
      bad++;
      $display("FAIL gl_c41 state=%0d want 0", state_o);
    end
    lock_i = 2'b01;
    goto(42);
    lock_i = 2'b11;
    goto(62);
    total++;
    if (state_o !== 2'd0) begin
      bad++;
      $display("FAIL gl_c62 state=%0d want 0", state_o);
    end
    goto(101);
    total++;
    if (state_o !== 2'd0) begin
      bad++;
      $display("FAIL gl_c101 state=%0d want 0", state_o);
    end
    goto(102);
    total++;
    if (state_o !== 2'd1) begin
      bad++;
      $display("FAIL gl_c102 state=%0d want 1", state_o);
    end
  endtask

  task automatic test_soft_reset;
    int exp_rs;
    int t;
    goto(122);
    total++;
    if (stage_rstn_o !== 3'b001) begin
      bad++;
      $display("FAIL sr_c122 rstn=%b want 001", stage_rstn_o);
    end
    soft_rst_i = 1'b1;
    goto(123);
    soft_rst_i = 1'b0;
    total++;
    if (stage_rstn_o !== 3'b000 || state_o !== 2'd3 ||
        reseq_cnt_o !== 8'd1) begin
      bad++;
      $display("FAIL sr_c123 rstn=%b st=%0d rs=%0d want 000/3/1",
               stage_rstn_o, state_o, reseq_cnt_o);
    end
    goto(130);
    soft_rst_i = 1'b1;
    goto(131);
    soft_rst_i = 1'b0;
    total++;
    if (state_o !== 2'd3 || reseq_cnt_o !== 8'd1) begin
      bad++;
      $display("FAIL sr_hold st=%0d rs=%0d want 3/1",
               state_o, reseq_cnt_o);
    end
    goto(162);
    total++;
    if (state_o !== 2'd0) begin
      bad++;
      $display("FAIL sr_c162 state=%0d want 0", state_o);
    end
    goto(181);
    soft_rst_i = 1'b1;
    goto(182);
    soft_rst_i = 1'b0;
    goto(222);
    total++;
    if (state_o !== 2'd0) begin
      bad++;
      $display("FAIL sr_wait state=%0d want 0", state_o);
    end
    goto(242);
    total++;
    if (state_o !== 2'd1 || reseq_cnt_o !== 8'd1) begin
      bad++;
      $display("FAIL sr_c242 st=%0d rs=%0d want 1/1",
               state_o, reseq_cnt_o);
    end
    exp_rs = 1;
    for (int i = 0; i < 260; i++) begin
      t = 0;
      while (state_o !== 2'd1 && t < 400) begin
        @(negedge clki);
        t++;
      end
      if (t >= 400) begin
        total++;
        bad++;
        $display("FAIL sr_loop_timeout iter=%0d state=%0d want 1",
                 i, state_o);
        break;
      end
      soft_rst_i = 1'b1;
      @(negedge clki);
      soft_rst_i = 1'b0;
      exp_rs = (exp_rs < 255) ? exp_rs + 1 : 255;
      total++;
      if (reseq_cnt_o !== 8'(exp_rs) || state_o !== 2'd3) begin
        bad++;
        $display("FAIL sr_loop iter=%0d rs=%0d st=%0d want %0d/3",
                 i, reseq_cnt_o, state_o, exp_rs);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ticks();
    test_release();
    test_fault_run();
    test_async_reset();
    test_lock_glitch();
    test_soft_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
